multi_irq_controller: RTL and testbench

//  Multi-source interrupt controller sitting beside the fetch stage. Latches rising edges on NUM_IRQ lines, arbitrates, then drives a

---
 rtl/intc_pkg.sv | 29 ++
 rtl/multi_irq_controller_if.sv | 38 +++
 rtl/intc_arbiter.sv | 48 ++++
 rtl/multi_irq_controller.sv | 173 +++++++++++++++++
 tb/tb_multi_irq_controller.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/intc_pkg.sv
// intc_pkg: shared types and constants for the multi-source interrupt controller.
// Holds the sequencer state encoding, the injected instruction words and the
// opcode / function patterns that mark two-word instructions in fetch.
package intc_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LONG     = 3'd1,
    S_WAIT_JMP = 3'd2,
    S_BUBBLE   = 3'd3,
    S_PUSH1    = 3'd4,
    S_PUSH2    = 3'd5,
    S_VECTOR   = 3'd6
  } intc_state_e;

  localparam logic [15:0] BUBBLE_INSTR = 16'h07F8;
  localparam logic [15:0] INT_P1       = 16'hF480;
  localparam logic [15:0] INT_P2       = 16'hF4A0;

  localparam logic [4:0] OP_CALL1 = 5'b11000;
  localparam logic [4:0] OP_RET1  = 5'b11010;
  localparam logic [2:0] FUNC_IMM = 3'b100;

  // A two-word instruction in fetch: its second word must pass before the return PC is saved.
  function automatic logic isLong(input logic [4:0] opcode, input logic [2:0] func);
    return (func == FUNC_IMM) || (opcode == OP_RET1) || (opcode == OP_CALL1);
  endfunction

endpackage

// File: rtl/multi_irq_controller_if.sv
// multi_irq_controller_if: bundle between the fetch/decode pipeline (master)
// and the interrupt controller (slave).
interface multi_irq_controller_if #(
  parameter int NUM_IRQ = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 16
);

  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [4:0]         fetch_opcode;
  logic [2:0]         fetch_func;
  logic               fetch_is_jmp;
  logic [PC_W-1:0]    next_pc;

  logic               inj_valid;
  logic [INSTR_W-1:0] inj_instr;
  logic               inj_bubble;
  logic               save_pc_valid;
  logic [PC_W-1:0]    save_pc;
  logic               vector_valid;
  logic [PC_W-1:0]    vector_addr;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               busy;

  modport master (
    output irq, irq_mask, fetch_opcode, fetch_func, fetch_is_jmp, next_pc,
    input  inj_valid, inj_instr, inj_bubble, save_pc_valid, save_pc,
           vector_valid, vector_addr, irq_ack, busy
  );

  modport slave (
    input  irq, irq_mask, fetch_opcode, fetch_func, fetch_is_jmp, next_pc,
    output inj_valid, inj_instr, inj_bubble, save_pc_valid, save_pc,
           vector_valid, vector_addr, irq_ack, busy
  );

endinterface

// File: rtl/intc_arbiter.sv
// intc_arbiter: picks one source out of the eligible vector.
// Build macro MULTI_IRQ_RR_PRIORITY_EN: when defined the search starts at rrPtr
// and wraps (round robin); otherwise the lowest index always wins.
module intc_arbiter #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_IRQ-1:0] eligible,
`ifdef MULTI_IRQ_RR_PRIORITY_EN
  input  logic [ID_W-1:0]    rrPtr,
`endif
  output logic               grantValid,
  output logic [ID_W-1:0]    grantId,
  output logic [NUM_IRQ-1:0] grantOneHot
);

`ifdef MULTI_IRQ_RR_PRIORITY_EN
  // Round robin: first eligible index at or after rrPtr, wrapping at NUM_IRQ.
  always_comb begin
    int idx;
    idx         = 0;
    grantValid  = 1'b0;
    grantId     = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      idx = (int'(rrPtr) + k) % NUM_IRQ;
      if (!grantValid && eligible[idx]) begin
        grantValid = 1'b1;
        grantId    = ID_W'(idx);
      end
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest eligible index as the winner.
  always_comb begin
    grantValid = 1'b0;
    grantId    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grantValid = 1'b1;
        grantId    = ID_W'(i);
      end
    end
  end
`endif

  assign grantOneHot = grantValid ? (NUM_IRQ'(1) << grantId) : '0;

endmodule

// File: rtl/multi_irq_controller.sv
// multi_irq_controller: latches rising irq edges, arbitrates among enabled
// sources and injects bubble / INT_P1 / INT_P2 / vector redirect into decode.
// Build macro MULTI_IRQ_RR_PRIORITY_EN: round-robin arbitration starting after
// the last granted id (pointer resets to 0); undefined = fixed priority, 0 highest.
//
// state      | meaning
// S_IDLE     | no service in progress, arbitration active
// S_LONG     | second word of a two-word instruction passes untouched
// S_WAIT_JMP | bubble while the jump in fetch resolves; target becomes return PC
// S_BUBBLE   | bubble ahead of the interrupt words
// S_PUSH1    | INT_P1 injected, return PC presented on save_pc
// S_PUSH2    | INT_P2 injected
// S_VECTOR   | one-cycle fetch redirect to the vector address
module multi_irq_controller
  import intc_pkg::*;
#(
  parameter int              NUM_IRQ    = 4,
  parameter int              PC_W       = 32,
  parameter int              INSTR_W    = 16,
  parameter logic [PC_W-1:0] IVT_BASE   = '0,
  parameter int              VEC_STRIDE = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  multi_irq_controller_if.slave bus
);

  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  intc_state_e        state;
  intc_state_e        stateNext;
  logic [NUM_IRQ-1:0] irqQ;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] grantOneHot;
  logic [NUM_IRQ-1:0] ackVec;
  logic               grantValid;
  logic               grant;
  logic [ID_W-1:0]    grantId;
  logic [ID_W-1:0]    id;
  logic [PC_W-1:0]    savedPc;
  logic [PC_W-1:0]    vecAddr;
  logic               fetchLong;

  assign eligible  = pending & bus.irq_mask;
  assign grant     = (state == S_IDLE) && grantValid;
  assign ackVec    = grant ? grantOneHot : '0;
  assign fetchLong = isLong(bus.fetch_opcode, bus.fetch_func);
  assign vecAddr   = IVT_BASE + PC_W'(id) * PC_W'(VEC_STRIDE);

`ifdef MULTI_IRQ_RR_PRIORITY_EN
  logic [ID_W-1:0] rrPtr;

  // Round-robin pointer: next search starts one past the id just granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rrPtr <= '0;
    end else if (grant) begin
      rrPtr <= (int'(grantId) == NUM_IRQ - 1) ? '0 : grantId + ID_W'(1);
    end
  end

  intc_arbiter #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) uArbiter (
    .eligible    (eligible),
    .rrPtr       (rrPtr),
    .grantValid  (grantValid),
    .grantId     (grantId),
    .grantOneHot (grantOneHot)
  );
`else
  intc_arbiter #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) uArbiter (
    .eligible    (eligible),
    .grantValid  (grantValid),
    .grantId     (grantId),
    .grantOneHot (grantOneHot)
  );
`endif

  // Edge capture: a new rising edge beats a same-cycle acknowledge so it is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irqQ    <= '0;
      pending <= '0;
    end else begin
      irqQ    <= bus.irq;
      pending <= (pending & ~ackVec) | (bus.irq & ~irqQ);
    end
  end

  // Latch the granted id and the return PC (jump targets are taken one cycle later).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id      <= '0;
      savedPc <= '0;
    end else if (grant) begin
      id <= grantId;
      if (!bus.fetch_is_jmp) begin
        savedPc <= fetchLong ? bus.next_pc + PC_W'(1) : bus.next_pc;
      end
    end else if (state == S_WAIT_JMP) begin
      savedPc <= bus.next_pc;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state: fixed injection order, entry point chosen by what sits in fetch at the grant.
  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE: begin
        if (grant) begin
          if (bus.fetch_is_jmp) begin
            stateNext = S_WAIT_JMP;
          end else if (fetchLong) begin
            stateNext = S_LONG;
          end else begin
            stateNext = S_BUBBLE;
          end
        end
      end
      S_LONG:     stateNext = S_BUBBLE;
      S_WAIT_JMP: stateNext = S_PUSH1;
      S_BUBBLE:   stateNext = S_PUSH1;
      S_PUSH1:    stateNext = S_PUSH2;
      S_PUSH2:    stateNext = S_VECTOR;
      S_VECTOR:   stateNext = S_IDLE;
      default:    stateNext = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register; inj_instr reads zero when nothing is injected.
  always_comb begin
    bus.inj_valid     = 1'b0;
    bus.inj_instr     = '0;
    bus.inj_bubble    = 1'b0;
    bus.save_pc_valid = 1'b0;
    bus.vector_valid  = 1'b0;
    case (state)
      S_WAIT_JMP, S_BUBBLE: begin
        bus.inj_valid  = 1'b1;
        bus.inj_bubble = 1'b1;
        bus.inj_instr  = INSTR_W'(BUBBLE_INSTR);
      end
      S_PUSH1: begin
        bus.inj_valid     = 1'b1;
        bus.inj_instr     = INSTR_W'(INT_P1);
        bus.save_pc_valid = 1'b1;
      end
      S_PUSH2: begin
        bus.inj_valid = 1'b1;
        bus.inj_instr = INSTR_W'(INT_P2);
      end
      S_VECTOR: begin
        bus.vector_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.save_pc     = savedPc;
  assign bus.vector_addr = (state == S_VECTOR) ? vecAddr : '0;
  assign bus.irq_ack     = ackVec;
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_multi_irq_controller.sv
// tb_multi_irq_controller: scoreboard bench. Each stimulus pushes the expected
// service (ack, return PC, vector, sequence kind); a negedge monitor pops it on
// irq_ack and checks every cycle of the injected sequence.
module tb_multi_irq_controller;
  import intc_pkg::*;

  localparam int              NUM_IRQ     = 4;
  localparam int              PC_W        = 32;
  localparam int              INSTR_W     = 16;
  localparam logic [PC_W-1:0] IVT_BASE_TB = 32'h0000_0000;
  localparam int              VEC_STRIDE_TB = 2;

  typedef enum int {K_NORM = 0, K_LONG = 1, K_JMP = 2} kind_e;

  typedef struct {
    logic [NUM_IRQ-1:0] ack;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    vec;
    kind_e              kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  exp_t  expQ[$];
  exp_t  cur;
  bit    inSeq;
  bit    monEn;
  int    off;
  int    monPhase;
  int    nChecks;
  int    nPass;
  logic  [21:0] obsBundle;

  always #5 clk = ~clk;

  multi_irq_controller_if #(.NUM_IRQ(NUM_IRQ), .PC_W(PC_W), .INSTR_W(INSTR_W)) ifc ();

  multi_irq_controller #(
    .NUM_IRQ    (NUM_IRQ),
    .PC_W       (PC_W),
    .INSTR_W    (INSTR_W),
    .IVT_BASE   (IVT_BASE_TB),
    .VEC_STRIDE (VEC_STRIDE_TB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  assign obsBundle = {ifc.busy, |ifc.irq_ack, ifc.inj_valid, ifc.inj_valid & ifc.inj_bubble,
                      ifc.inj_valid ? ifc.inj_instr : 16'h0000, ifc.save_pc_valid, ifc.vector_valid};

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // {busy, ack, inj_valid, bubble, instr, save_pc_valid, vector_valid} for cycle k after the ack.
  function automatic logic [21:0] expBundle(input kind_e kind, input int k);
    int phase;
    logic [21:0] b;
    phase = (kind == K_LONG) ? k - 1 : k;
    case (phase)
      0:       b = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      1:       b = {1'b1, 1'b0, 1'b1, 1'b1, 16'h07F8, 1'b0, 1'b0};
      2:       b = {1'b1, 1'b0, 1'b1, 1'b0, 16'hF480, 1'b1, 1'b0};
      3:       b = {1'b1, 1'b0, 1'b1, 1'b0, INT_P2,   1'b0, 1'b0};
      default: b = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    endcase
    return b;
  endfunction

  function automatic logic [PC_W-1:0] vecOf(input int idx);
    return IVT_BASE_TB + PC_W'(idx * VEC_STRIDE_TB);
  endfunction

  always @(negedge clk) begin
    if (!monEn) begin
      inSeq = 1'b0;
    end else if (inSeq) begin
      off++;
      monPhase = (cur.kind == K_LONG) ? off - 1 : off;
      checkVal($sformatf("seq_k%0d_c%0d", cur.kind, off), obsBundle, expBundle(cur.kind, off));
      if (monPhase == 2) checkVal("save_pc", ifc.save_pc, cur.pc);
      if (monPhase == 4) checkVal("vector_addr", ifc.vector_addr, cur.vec);
      if (monPhase >= 4 || off >= 6) inSeq = 1'b0;
    end else if (ifc.irq_ack != '0) begin
      if (expQ.size() == 0) begin
        checkVal("unexpected_ack", ifc.irq_ack, '0);
      end else begin
        cur = expQ.pop_front();
        checkVal("irq_ack", ifc.irq_ack, cur.ack);
        checkVal("ack_while_idle", ifc.busy, 1'b0);
        inSeq = 1'b1;
        off   = 0;
      end
    end else begin
      checkVal("idle_quiet", {ifc.busy, ifc.inj_valid, ifc.save_pc_valid, ifc.vector_valid}, '0);
    end
  end

  task automatic pushExp(input logic [NUM_IRQ-1:0] ack, input logic [PC_W-1:0] pc,
                         input logic [PC_W-1:0] vec, input kind_e kind);
    exp_t e;
    e.ack = ack; e.pc = pc; e.vec = vec; e.kind = kind;
    expQ.push_back(e);
  endtask

  task automatic setFetch(input logic [4:0] opc, input logic [2:0] fn, input logic jmp,
                          input logic [PC_W-1:0] pc);
    ifc.fetch_opcode = opc;
    ifc.fetch_func   = fn;
    ifc.fetch_is_jmp = jmp;
    ifc.next_pc      = pc;
  endtask

  task automatic pulseMask(input logic [NUM_IRQ-1:0] m);
    @(posedge clk); #1 ifc.irq = m;
    @(posedge clk); #1 ifc.irq = '0;
  endtask

  task automatic waitAck(input int maxCyc);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (ifc.irq_ack == '0 && n < maxCyc);
    checkVal("ack_arrived", ifc.irq_ack != '0, 1'b1);
  endtask

  task automatic waitDone(input int maxCyc);
    int n = 0;
    while ((expQ.size() != 0 || inSeq) && n < maxCyc) begin
      @(negedge clk); #1;
      n++;
    end
    checkVal("seq_drain", expQ.size() + int'(inSeq), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    nChecks = 0; nPass = 0; monEn = 1'b0; inSeq = 1'b0; off = 0; monPhase = 0;
    rst_n = 1'b0;
    ifc.irq = '0;
    ifc.irq_mask = '1;
    setFetch(5'b00001, 3'b000, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("reset_ctrl", obsBundle, '0);
    checkVal("reset_save_pc", ifc.save_pc, '0);
    checkVal("reset_vector_addr", ifc.vector_addr, '0);
    @(posedge clk); #1 rst_n = 1'b1; monEn = 1'b1;

    // plain instruction in fetch
    setFetch(5'b00001, 3'b000, 1'b0, 32'h40);
    pushExp(4'b0100, 32'h40, vecOf(2), K_NORM);
    pulseMask(4'b0100);
    waitDone(40);

    // immediate-prefix (func 100): return PC skips the second word
    setFetch(5'b00010, 3'b100, 1'b0, 32'h10);
    pushExp(4'b0001, 32'h11, vecOf(0), K_LONG);
    pulseMask(4'b0001);
    waitDone(40);

    // CALL at the top of the address space: return PC wraps to 0
    setFetch(5'b11000, 3'b000, 1'b0, 32'hFFFF_FFFF);
    pushExp(4'b1000, 32'h0, vecOf(3), K_LONG);
    pulseMask(4'b1000);
    waitDone(40);

    // unresolved jump: target presented during WAIT_JMP becomes the return PC
    setFetch(5'b00001, 3'b000, 1'b1, 32'h70);
    pushExp(4'b0100, 32'h80, vecOf(2), K_JMP);
    pulseMask(4'b0100);
    waitAck(20);
    @(posedge clk); #1 ifc.next_pc = 32'h80;
    @(posedge clk); #1 ifc.fetch_is_jmp = 1'b0;
    waitDone(40);

    // RET, also leaves the last granted id at 1
    setFetch(5'b11010, 3'b000, 1'b0, 32'h200);
    pushExp(4'b0010, 32'h201, vecOf(1), K_LONG);
    pulseMask(4'b0010);
    waitDone(40);

    // two simultaneous sources
    setFetch(5'b00001, 3'b000, 1'b0, 32'h100);
`ifdef MULTI_IRQ_RR_PRIORITY_EN
    pushExp(4'b1000, 32'h100, vecOf(3), K_NORM);
    pushExp(4'b0010, 32'h100, vecOf(1), K_NORM);
`else
    pushExp(4'b0010, 32'h100, vecOf(1), K_NORM);
    pushExp(4'b1000, 32'h100, vecOf(3), K_NORM);
`endif
    pulseMask(4'b1010);
    waitDone(60);

    // masked source stays pending, serviced once enabled
    ifc.irq_mask = 4'b1110;
    setFetch(5'b00001, 3'b000, 1'b0, 32'h300);
    pulseMask(4'b0001);
    repeat (5) @(posedge clk);
    pushExp(4'b0001, 32'h300, vecOf(0), K_NORM);
    #1 ifc.irq_mask = '1;
    waitDone(40);

    // new edge on the same cycle as that source's grant must survive
    ifc.irq_mask = 4'b1011;
    setFetch(5'b00001, 3'b000, 1'b0, 32'h20);
    pulseMask(4'b0100);
    @(posedge clk); #1;
    pushExp(4'b0100, 32'h20, vecOf(2), K_NORM);
    pushExp(4'b0100, 32'h20, vecOf(2), K_NORM);
    ifc.irq_mask = '1;
    ifc.irq = 4'b0100;
    @(posedge clk); #1 ifc.irq = '0;
    waitDone(60);

    // reset during PUSH2 with another source pending
    setFetch(5'b00001, 3'b000, 1'b0, 32'h44);
    pushExp(4'b0010, 32'h44, vecOf(1), K_NORM);
    pulseMask(4'b0010);
    waitAck(20);
    pulseMask(4'b1000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    monEn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkVal("midrst_ctrl", obsBundle, '0);
    checkVal("midrst_save_pc", ifc.save_pc, '0);
    checkVal("midrst_vector_addr", ifc.vector_addr, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | ifc.busy | (|ifc.irq_ack);
    end
    checkVal("pending_cleared", seen, 1'b0);
    checkVal("queue_after_rst", expQ.size(), 0);

    // service resumes normally after reset
    monEn = 1'b1;
    pushExp(4'b1000, 32'h44, vecOf(3), K_NORM);
    pulseMask(4'b1000);
    waitDone(40);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
